prng_dataout: RTL and testbench

// - Datapath stage driven by the PRNG control FSM: consumes its 2-bit state, produces data_done back to it.
// - Holds a Galois LFSR that steps in SHIFT and holds in IDLE/DATAOUT.
// - On entering DATAOUT, snapshots the LFSR and streams it out as OUT_W-bit words over a valid/ready handshake.
// - Pulses data_done after the last word is accepted, so the FSM returns to SHIFT.

---
 rtl/prng_pkg.sv | 16 +
 rtl/prng_dataout_if.sv | 17 +
 rtl/prng_lfsr.sv | 37 +++
 rtl/prng_dataout.sv | 95 +++++++++
 tb/tb_prng_dataout.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG control FSM and its datapath stage.
//   prng_state_e       : 2-bit FSM state encoding (2'b11 is treated as IDLE)
//   PRNG_TAPS_DEFAULT  : Galois feedback mask for x^32+x^22+x^2+x+1
//   PRNG_SEED_DEFAULT  : LFSR reset value, also substituted for a zero seed
package prng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SHIFT   = 2'b01,
    ST_DATAOUT = 2'b10
  } prng_state_e;

  localparam logic [31:0] PRNG_TAPS_DEFAULT = 32'h8020_0003;
  localparam logic [31:0] PRNG_SEED_DEFAULT = 32'h0000_0001;

endpackage

// File: rtl/prng_dataout_if.sv
// Output word stream of the PRNG datapath stage.
//   out_ready  : consumer accepts the current word
//   rand_data  : current output word (OUT_W bits)
//   rand_valid : rand_data is valid
//   data_done  : one-cycle pulse after the last word of a snapshot is accepted
// master = producer (prng_dataout), slave = consumer.
interface prng_dataout_if #(
  parameter int unsigned OUT_W = 8
);
  logic             out_ready;
  logic [OUT_W-1:0] rand_data;
  logic             rand_valid;
  logic             data_done;

  modport master (input out_ready, output rand_data, output rand_valid, output data_done);
  modport slave  (output out_ready, input rand_data, input rand_valid, input data_done);
endinterface

// File: rtl/prng_lfsr.sv
// Galois LFSR (right shift) with synchronous seed load.
//   clk, rstn : clock, asynchronous active-low reset (q resets to SEED_DEFAULT)
//   load      : load seed (SEED_DEFAULT if seed is zero); has priority over step
//   seed      : seed value
//   step      : advance one LFSR step
//   q         : current LFSR contents
module prng_lfsr
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = PRNG_TAPS_DEFAULT,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = PRNG_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_lfsr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr <= SEED_DEFAULT;
    end else if (load) begin
      // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
      r_lfsr <= (seed == '0) ? SEED_DEFAULT : seed;
    end else if (step) begin
      r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    end
  end

  assign q = r_lfsr;

endmodule

// File: rtl/prng_dataout.sv
// PRNG datapath stage: steps the LFSR in SHIFT, snapshots it on entry to
// DATAOUT and streams the snapshot LSW-first over a valid/ready handshake,
// pulsing data_done after the last word so the FSM returns to SHIFT.
//   clk, rstn : clock, asynchronous active-low reset
//   state     : FSM state (prng_state_e encoding, 2'b11 = IDLE)
//   seed_load : synchronous seed load strobe
//   seed      : seed value
//   bus       : output word stream (master side)
//   lfsr_q    : current LFSR contents
module prng_dataout
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      OUT_W        = 8,
  parameter logic [WIDTH-1:0] TAPS         = PRNG_TAPS_DEFAULT,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = PRNG_SEED_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            state,
  input  logic                  seed_load,
  input  logic [WIDTH-1:0]      seed,
  prng_dataout_if.master        bus,
  output logic [WIDTH-1:0]      lfsr_q
);

  localparam int unsigned NWORDS = WIDTH / OUT_W;
  localparam int unsigned CNT_W  = $clog2(NWORDS) + 1;

  logic [WIDTH-1:0] w_lfsr;
  logic             w_is_dataout;
  logic             w_entry;
  logic             w_xfer;
  logic             w_last;

  logic [WIDTH-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_done;
  logic             r_prev_dataout;

  prng_lfsr #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .load (seed_load),
    .seed (seed),
    .step (state == ST_SHIFT),
    .q    (w_lfsr)
  );

  assign w_is_dataout = (state == ST_DATAOUT);
  assign w_entry      = w_is_dataout && !r_prev_dataout;
  assign w_xfer       = r_valid && bus.out_ready;
  assign w_last       = (r_cnt == CNT_W'(NWORDS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf          <= '0;
      r_cnt          <= '0;
      r_valid        <= 1'b0;
      r_done         <= 1'b0;
      r_prev_dataout <= 1'b0;
    end else begin
      r_prev_dataout <= w_is_dataout;
      r_done         <= 1'b0;
      if (!w_is_dataout) begin
        // Leaving DATAOUT mid-stream aborts the transfer without a done pulse.
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else if (w_entry) begin
        // Snapshot takes the pre-edge LFSR value, so a same-cycle seed_load is not seen.
        r_buf   <= w_lfsr;
        r_cnt   <= '0;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_buf <= r_buf >> OUT_W;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign bus.rand_data  = r_buf[OUT_W-1:0];
  assign bus.rand_valid = r_valid;
  assign bus.data_done  = r_done;
  assign lfsr_q         = w_lfsr;

endmodule

// File: tb/tb_prng_dataout.sv
module tb_prng_dataout;
  import prng_pkg::*;

  logic        clk;
  logic        rstn;
  logic [1:0]  state;
  logic        seed_load;
  logic [31:0] seed;
  logic [31:0] lfsr_q;

  prng_dataout_if #(.OUT_W(8)) bif ();

  prng_dataout #(
    .WIDTH        (32),
    .OUT_W        (8),
    .TAPS         (32'h8020_0003),
    .SEED_DEFAULT (32'h0000_0001)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .state     (state),
    .seed_load (seed_load),
    .seed      (seed),
    .bus       (bif.master),
    .lfsr_q    (lfsr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_lfsr;
  logic [7:0]  sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] v);
    logic [31:0] s;
    s = {1'b0, v[31:1]};
    if (v[0]) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  task automatic do_seed(input logic [31:0] v);
    seed_load = 1'b1;
    seed      = v;
    tick();
    seed_load = 1'b0;
    m_lfsr    = (v == 32'd0) ? 32'h0000_0001 : v;
    chk("seed_load", 64'(lfsr_q), 64'(m_lfsr));
  endtask

  task automatic do_shift(input int n);
    state = ST_SHIFT;
    for (int i = 0; i < n; i++) begin
      tick();
      m_lfsr = model_step(m_lfsr);
      chk("shift_step", 64'(lfsr_q), 64'(m_lfsr));
    end
    state = ST_IDLE;
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating.
  // ld: apply seed_load with sval during the stream.
  task automatic stream(input int mode, input bit ld, input logic [31:0] sval);
    logic [31:0] snap;
    logic [7:0]  held;
    bit          stalled;
    bit          prev_done;
    bit          loading;
    int          done_cnt;
    int          k;
    snap      = m_lfsr;
    held      = 8'd0;
    stalled   = 1'b0;
    prev_done = 1'b0;
    done_cnt  = 0;
    k         = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(snap[8*i +: 8]);
    state         = ST_DATAOUT;
    bif.out_ready = 1'b0;
    chk("entry_valid_pre", 64'(bif.rand_valid), 64'd0);
    tick();
    chk("entry_valid_lat", 64'(bif.rand_valid), 64'd1);
    for (int c = 0; c < 40 && (sb.size() > 0 || done_cnt == 0); c++) begin
      bif.out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      k++;
      loading   = ld && (c == 1);
      seed_load = loading;
      seed      = sval;
      if (stalled) chk("stall_hold", 64'(bif.rand_data), 64'(held));
      stalled = 1'b0;
      if (bif.rand_valid && bif.out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else chk("word", 64'(bif.rand_data), 64'(sb.pop_front()));
      end else if (bif.rand_valid) begin
        stalled = 1'b1;
        held    = bif.rand_data;
      end
      tick();
      seed_load = 1'b0;
      if (loading) m_lfsr = (sval == 32'd0) ? 32'h0000_0001 : sval;
      if (bif.data_done) begin
        chk("done_not_back_to_back", 64'(prev_done), 64'd0);
        done_cnt++;
      end
      prev_done = bif.data_done;
      chk("lfsr_hold", 64'(lfsr_q), 64'(m_lfsr));
    end
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("valid_after_last", 64'(bif.rand_valid), 64'd0);
    // Stay in DATAOUT one more cycle: no second done, no re-snapshot.
    bif.out_ready = 1'b1;
    tick();
    chk("done_single_cycle", 64'(bif.data_done), 64'd0);
    chk("no_resnapshot", 64'(bif.rand_valid), 64'd0);
    state         = ST_IDLE;
    bif.out_ready = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] shift_exp[3];
    shift_exp[0] = 32'h8020_0003;
    shift_exp[1] = 32'hC030_0002;
    shift_exp[2] = 32'h6018_0001;

    rstn          = 1'b0;
    state         = ST_IDLE;
    seed_load     = 1'b0;
    seed          = 32'd0;
    bif.out_ready = 1'b0;
    m_lfsr        = 32'h0000_0001;
    tick();
    tick();
    chk("reset_lfsr", 64'(lfsr_q), 64'h1);
    chk("reset_valid", 64'(bif.rand_valid), 64'd0);
    chk("reset_done", 64'(bif.data_done), 64'd0);
    chk("reset_data", 64'(bif.rand_data), 64'd0);
    rstn = 1'b1;
    tick();

    // Known step sequence from seed 1.
    do_seed(32'h0000_0001);
    state = ST_SHIFT;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("shift_const", 64'(lfsr_q), 64'(shift_exp[i]));
    end
    state  = ST_IDLE;
    m_lfsr = 32'h6018_0001;
    tick();
    chk("idle_hold", 64'(lfsr_q), 64'(m_lfsr));

    // Stream C0300002 with out_ready held high: words 02,00,30,C0.
    do_seed(32'hC030_0002);
    stream(0, 1'b0, 32'd0);

    // Backpressure.
    do_shift(5);
    stream(1, 1'b0, 32'd0);

    // Zero seed falls back to the default; seed_load during DATAOUT leaves snapshot intact.
    do_seed(32'd0);
    do_shift(4);
    stream(0, 1'b1, 32'hDEAD_BEEF);
    do_shift(2);

    // Abort: leave DATAOUT after one word.
    state = ST_DATAOUT;
    tick();
    chk("abort_valid_up", 64'(bif.rand_valid), 64'd1);
    chk("abort_first_word", 64'(bif.rand_data), 64'(m_lfsr[7:0]));
    bif.out_ready = 1'b1;
    tick();
    state         = ST_IDLE;
    bif.out_ready = 1'b0;
    tick();
    chk("abort_valid_down", 64'(bif.rand_valid), 64'd0);
    chk("abort_no_done", 64'(bif.data_done), 64'd0);
    tick();
    chk("abort_no_done_late", 64'(bif.data_done), 64'd0);

    // Asynchronous reset after two words.
    do_shift(3);
    state = ST_DATAOUT;
    tick();
    bif.out_ready = 1'b1;
    tick();
    tick();
    chk("pre_reset_valid", 64'(bif.rand_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("async_lfsr", 64'(lfsr_q), 64'h1);
    chk("async_valid", 64'(bif.rand_valid), 64'd0);
    chk("async_done", 64'(bif.data_done), 64'd0);
    chk("async_data", 64'(bif.rand_data), 64'd0);
    state         = ST_IDLE;
    bif.out_ready = 1'b0;
    tick();
    rstn   = 1'b1;
    m_lfsr = 32'h0000_0001;
    tick();
    stream(0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
